// File: rtl/gate_bist_pkg.sv
// Shared types and truth-table constants for the gate BIST controller.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Settle counter width covers SETTLE_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;

endpackage

// File: rtl/gate_bist_timer.sv
// Settle counter: clears on load, counts up on inc, flags terminal count.
module gate_bist_timer
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/gate_bist.sv
// Gate BIST controller: walks all input vectors, samples the gate after a settle
// time and accumulates mismatches against EXPECT.
//   state | meaning
//   IDLE  | waiting for start
//   HOLD  | driving dut_in, sampling dut_out at terminal count
//   DONE  | one-cycle done pulse, pass registered
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int                N_IN          = 2,
  parameter int unsigned       SETTLE_CYCLES = 1,
  parameter logic [2**N_IN-1:0] EXPECT       = TT_XOR2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_t      state;
  logic        tc;
  logic        timer_load;
  logic        timer_inc;
  logic        mismatch;
  logic [N_IN:0] err_next;

  // Counter only runs in HOLD; it restarts at every sample so each vector gets a full settle.
  assign timer_load = (state != HOLD) || tc;
  assign timer_inc  = (state == HOLD);

  gate_bist_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .inc  (timer_inc),
    .tc   (tc)
  );

  // Case-inequality so an undriven or X gate output is reported as a failure.
  assign mismatch = (dut_out !== EXPECT[dut_in]);
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      if (state != HOLD && start) begin
        state          <= HOLD;
        dut_in         <= '0;
        busy           <= 1'b1;
        pass           <= 1'b0;
        err_count      <= '0;
        fail_valid     <= 1'b0;
        first_fail_vec <= '0;
      end else begin
        case (state)
          HOLD: begin
            if (tc) begin
              err_count <= err_next;
              if (mismatch && !fail_valid) begin
                first_fail_vec <= dut_in;
                fail_valid     <= 1'b1;
              end
              if (dut_in == LAST_VEC) begin
                state  <= DONE;
                done   <= 1'b1;
                busy   <= 1'b0;
                pass   <= (err_next == '0);
                dut_in <= '0;
              end else begin
                dut_in <= dut_in + N_IN'(1);
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: randomized gate truth tables, reference model
// counts disagreements per run, monitor checks the vector walk and done results.
module tb_gate_bist;
  import gate_bist_pkg::*;

  typedef struct {
    int e0;
    int s;
    int cyc;
    int errs;
    int first;
    int fv;
    int ps;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nfail = 0;

  logic       start0, dut_out0, busy0, done0, pass0, fv0;
  logic [1:0] dut_in0, ff0;
  logic [2:0] err0;
  logic [3:0] gt0;

  logic       start1, dut_out1, busy1, done1, pass1, fv1;
  logic [1:0] dut_in1, ff1;
  logic [2:0] err1;
  logic [3:0] gt1;

  assign dut_out0 = gt0[dut_in0];
  assign dut_out1 = gt1[dut_in1];

  gate_bist u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(dut_out0),
    .dut_in(dut_in0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .first_fail_vec(ff0)
  );

  gate_bist #(.N_IN(2), .SETTLE_CYCLES(3), .EXPECT(TT_AND2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dut_out1),
    .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .first_fail_vec(ff1)
  );

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t ev0, ev1;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference: a run over all four vectors reports how many gate outputs disagree
  // with the expected table, the lowest disagreeing vector, and finishes after
  // 4*(settle+1) cycles.
  function automatic exp_t model(input logic [3:0] gt, input logic [3:0] ex,
                                 input int e0, input int s);
    exp_t r;
    r.e0 = e0; r.s = s; r.errs = 0; r.first = 0; r.fv = 0;
    for (int v = 0; v < 4; v++) begin
      if (gt[v] != ex[v]) begin
        if (r.fv == 0) begin r.first = v; r.fv = 1; end
        r.errs++;
      end
    end
    r.ps  = (r.errs == 0) ? 1 : 0;
    r.cyc = e0 + 4 * (s + 1);
    return r;
  endfunction

  task automatic chk_done(input string t, input exp_t e, input int din, input int bsy,
                          input int ps, input int ec, input int fv, input int ff);
    chk({t, "_done_cycle"}, cyc, e.cyc);
    chk({t, "_err_count"}, ec, e.errs);
    chk({t, "_fail_valid"}, fv, e.fv);
    chk({t, "_first_fail"}, ff, e.first);
    chk({t, "_pass"}, ps, e.ps);
    chk({t, "_busy_in_done"}, bsy, 0);
    chk({t, "_dut_in_in_done"}, din, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done0) begin
        chk("d0_done_expected", (sb0.size() > 0) ? 1 : 0, 1);
        if (sb0.size() > 0) begin
          ev0 = sb0.pop_front();
          chk_done("d0", ev0, dut_in0, busy0, pass0, err0, fv0, ff0);
        end
      end else if (sb0.size() > 0 && cyc >= sb0[0].e0) begin
        chk("d0_busy", busy0, 1);
        chk("d0_dut_in", dut_in0, (cyc - sb0[0].e0) / (sb0[0].s + 1));
      end
      if (done1) begin
        chk("d1_done_expected", (sb1.size() > 0) ? 1 : 0, 1);
        if (sb1.size() > 0) begin
          ev1 = sb1.pop_front();
          chk_done("d1", ev1, dut_in1, busy1, pass1, err1, fv1, ff1);
        end
      end else if (sb1.size() > 0 && cyc >= sb1[0].e0) begin
        chk("d1_busy", busy1, 1);
        chk("d1_dut_in", dut_in1, (cyc - sb1[0].e0) / (sb1[0].s + 1));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb0.size() + sb1.size(), 0);
    sb0.delete();
    sb1.delete();
  endtask

  task automatic run0(input logic [3:0] gt, input int poke);
    @(negedge clk);
    gt0 = gt;
    start0 = 1'b1;
    sb0.push_back(model(gt, TT_XOR2, cyc + 1, 1));
    @(negedge clk);
    start0 = 1'b0;
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end
    drain();
  endtask

  task automatic run1(input logic [3:0] gt);
    @(negedge clk);
    gt1 = gt;
    start1 = 1'b1;
    sb1.push_back(model(gt, TT_AND2, cyc + 1, 3));
    @(negedge clk);
    start1 = 1'b0;
    drain();
  endtask

  task automatic chk_zero(input string t, input int din, input int bsy, input int dn,
                          input int ps, input int ec, input int fv, input int ff);
    chk({t, "_dut_in"}, din, 0);
    chk({t, "_busy"}, bsy, 0);
    chk({t, "_done"}, dn, 0);
    chk({t, "_pass"}, ps, 0);
    chk({t, "_err_count"}, ec, 0);
    chk({t, "_fail_valid"}, fv, 0);
    chk({t, "_first_fail"}, ff, 0);
  endtask

  initial begin
    exp_t a;
    int n;
    start0 = 1'b0; start1 = 1'b0;
    gt0 = TT_XOR2; gt1 = TT_AND2;
    repeat (3) @(negedge clk);
    chk_zero("rst0", dut_in0, busy0, done0, pass0, err0, fv0, ff0);
    chk_zero("rst1", dut_in1, busy1, done1, pass1, err1, fv1, ff1);
    rst_n = 1'b1;

    run0(TT_XOR2, 0);
    run0(4'b0000, 0);
    run0(TT_XNOR2, 0);
    run0(TT_XOR2, 3);

    // Abort a stuck-at-0 run at vector 2, after one mismatch is already recorded.
    @(negedge clk);
    gt0 = 4'b0000;
    start0 = 1'b1;
    sb0.push_back(model(4'b0000, TT_XOR2, cyc + 1, 1));
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (dut_in0 != 2'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_vec2", dut_in0, 2);
    chk("abort_err_before_reset", err0, 1);
    #2 rst_n = 1'b0;
    #1;
    sb0.delete();
    chk_zero("abort", dut_in0, busy0, done0, pass0, err0, fv0, ff0);
    @(negedge clk);
    rst_n = 1'b1;
    run0(TT_XOR2, 0);

    for (int i = 0; i < 8; i++) run0(4'($urandom_range(0, 15)), 0);

    // Back-to-back runs with start held through the first done.
    @(negedge clk);
    gt1 = TT_AND2;
    start1 = 1'b1;
    a = model(TT_AND2, TT_AND2, cyc + 1, 3);
    sb1.push_back(a);
    sb1.push_back(model(TT_AND2, TT_AND2, a.cyc + 1, 3));
    repeat (18) @(negedge clk);
    start1 = 1'b0;
    drain();
    chk("d1_pass_held", pass1, 1);

    for (int i = 0; i < 3; i++) run1(4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
